// File: rtl/gzip_pipe.sv
// gzip_pipe: two-stage pipelined bit zip/unzip (generalised shuffle) unit.
//
// Stage operation S(N) swaps the two middle N-bit fields of every 4N-bit
// block. in_ctrl[i] (i >= 1) enables S(2^(i-1)); zip applies the enabled
// stages largest-N first, unzip smallest-N first. Stage s1 applies the first
// CW-3 stages of the sequence, stage s2 the last two.
//
// Configuration macro: GZIP_PIPE_UNZIP_EN
//   defined   -> in_ctrl[0] selects zip (0) / unzip (1)
//   undefined -> unzip logic absent, in_ctrl[0] ignored, always zip
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready       operation handshake (in_ready is combinational)
//   in_data [XLEN]          operand
//   in_ctrl [CW]            stage enables [CW-1:1], mode [0]
//   in_tag  [TAGW]          opaque tag returned with the result
//   out_valid/out_ready     result handshake
//   out_data [XLEN]         result (registered)
//   out_tag  [TAGW]         tag of the result (registered)
module gzip_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 4,
    localparam int unsigned CW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [CW-1:0]   in_ctrl,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [TAGW-1:0] out_tag
);

    localparam int unsigned NSTG = CW - 1;   // total stage count
    localparam int unsigned S1N  = CW - 3;   // stages handled in s1

    // S(2^k): swap the middle two fields of each 4N-bit block using masks
    function automatic logic [XLEN-1:0] swap_mid(input logic [XLEN-1:0] d,
                                                 input int unsigned k);
        logic [XLEN-1:0] pat;
        logic [XLEN-1:0] lo_f;
        logic [XLEN-1:0] hi_f;
        int unsigned     n;
        n    = 32'd1 << k;
        pat  = (XLEN'(1) << n) - XLEN'(1);
        lo_f = '0;
        for (int unsigned b = 0; b < XLEN; b += 4 * n) begin
            lo_f |= pat << (b + n);
        end
        hi_f = lo_f << n;
        return (d & ~(lo_f | hi_f)) | ((d >> n) & lo_f) | ((d << n) & hi_f);
    endfunction

    logic            in_mode;
    logic            s1_mode;
    logic            s1_valid;
    logic [XLEN-1:0] s1_data;
    logic [1:0]      s1_en2;
    logic [TAGW-1:0] s1_tag;
    logic [XLEN-1:0] s1_d;
    logic [1:0]      en2_d;
    logic [XLEN-1:0] s2_d;
    logic            s1_load;
    logic            s2_load;

`ifdef GZIP_PIPE_UNZIP_EN
    assign in_mode = in_ctrl[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_mode <= 1'b0;
        end else if (s1_load) begin
            s1_mode <= in_mode;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = in_ctrl[0];
    assign in_mode     = 1'b0;
    assign s1_mode     = 1'b0;
`endif

    // Elastic handshake: a stage may load whenever its content moves on
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // s1 datapath; also picks which two enables s2 will need
    always_comb begin
        s1_d = in_data;
        if (in_mode) begin
            for (int k = 0; k < int'(S1N); k++) begin
                if (in_ctrl[k+1]) s1_d = swap_mid(s1_d, k);
            end
            en2_d = {in_ctrl[S1N+2], in_ctrl[S1N+1]};
        end else begin
            for (int k = int'(NSTG) - 1; k >= 2; k--) begin
                if (in_ctrl[k+1]) s1_d = swap_mid(s1_d, k);
            end
            en2_d = in_ctrl[2:1];
        end
    end

    // s2 datapath: en2[0] is the lower-N stage, en2[1] the higher one
    always_comb begin
        s2_d = s1_data;
        if (s1_mode) begin
            if (s1_en2[0]) s2_d = swap_mid(s2_d, S1N);
            if (s1_en2[1]) s2_d = swap_mid(s2_d, S1N + 1);
        end else begin
            if (s1_en2[1]) s2_d = swap_mid(s2_d, 1);
            if (s1_en2[0]) s2_d = swap_mid(s2_d, 0);
        end
    end

    // Pipeline registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_en2    <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                s1_data  <= s1_d;
                s1_en2   <= en2_d;
                s1_tag   <= in_tag;
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                out_data  <= s2_d;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule
